param_stopwatch: RTL and testbench
==================================

PARAM_STOPWATCH -- requirements
Module: param_stopwatch

Interface
REQ-001 The block SHALL have parameter DVSR, default 10000000: clk cycles per 0.1 s tick; legal values >= 2.
REQ-002 The block SHALL have parameter DIGITS, default 4: BCD digit count, legal values 4..6.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port go, input, 1 bit: level, count while high.
REQ-006 The block SHALL have port clr, input, 1 bit: synchronous clear.
REQ-007 The block SHALL have port up, input, 1 bit: 1 = count up, 0 = count down.
REQ-008 The block SHALL have port load, input, 1 bit: synchronous preset strobe.
REQ-009 The block SHALL have port load_val, input, 4*DIGITS bits: preset value, packed BCD with digit 0 in the LSBs.
REQ-010 The block SHALL have port bcd, output, 4*DIGITS bits: current count, packed like load_val.
REQ-011 The block SHALL have port running, output, 1 bit: high while in state RUN.
REQ-012 The block SHALL have port expired, output, 1 bit: high while in state DONE.
REQ-013 The block SHALL have port done_tick, output, 1 bit: one-cycle pulse on countdown expiry.
REQ-014 The block SHALL have port wrap_tick, output, 1 bit: one-cycle pulse on count-up rollover.

Function
REQ-015 Digit moduli SHALL be: d0 tenths mod 10; d1 seconds mod 10; d2 tens of seconds mod 6; d3 minutes mod 10; d4 tens of minutes mod 6; d5 hours mod 10.
REQ-016 The prescaler SHALL count 0..DVSR-1 only in RUN, hold its value in IDLE and DONE, and assert an internal tick in the cycle it equals DVSR-1 before wrapping to 0, giving a tick period of exactly DVSR cycles.
REQ-017 The FSM SHALL have states IDLE, RUN and DONE: IDLE->RUN when go=1; RUN->IDLE when go=0; DONE exits only on clr, load or reset.
REQ-018 Digit update on a tick, up=1: d0 increments; digit k>0 advances only when all lower digits are at modulus-1; a digit at modulus-1 wraps to 0.
REQ-019 Digit update on a tick, up=0: d0 decrements; digit k>0 advances only when all lower digits are 0; a digit at 0 wraps to modulus-1.
REQ-020 Up rollover: a tick with up=1 and all digits at modulus-1 SHALL clear all digits, pulse wrap_tick in the following cycle and stay in RUN.
REQ-021 Countdown expiry: a tick with up=0 taking the count to all-zero SHALL set all zero, enter DONE and pulse done_tick in the following cycle.
REQ-022 A tick with up=0 while the count is already all-zero SHALL leave the digits unchanged, enter DONE and pulse done_tick.
REQ-023 A change of up mid-run SHALL take effect at the next tick, without resetting digits or prescaler.
REQ-024 clr=1 SHALL zero all digits and the prescaler and force IDLE; go has effect from the following cycle.
REQ-025 load=1 SHALL copy load_val into the digits, zero the prescaler and force IDLE.
REQ-026 On load, any nibble >= its modulus SHALL be stored as modulus-1.
REQ-027 Priority SHALL be reset > clr > load > tick.
REQ-028 bcd, running and expired SHALL be registered outputs; done_tick and wrap_tick SHALL be registered one-cycle pulses.

Reset
REQ-029 reset=1 SHALL asynchronously set digits=0, prescaler=0, state=IDLE and done_tick=wrap_tick=running=expired=0 (lap_bcd=0 when present).
REQ-030 A reset asserted mid-count SHALL discard any partial prescaler count, and counting SHALL resume from 0 only after reset deasserts and go=1.

Configuration
REQ-031 With macro PARAM_STOPWATCH_LAP_EN defined, ports lap (input, 1 bit) and lap_bcd (output, 4*DIGITS bits) SHALL exist.
REQ-032 With PARAM_STOPWATCH_LAP_EN defined, lap=1 SHALL capture the current bcd into lap_bcd on that edge in any state, without disturbing counting.
REQ-033 With PARAM_STOPWATCH_LAP_EN defined, lap_bcd SHALL hold until the next lap, clr or reset; clr SHALL zero it; load SHALL not affect it.
REQ-034 Without PARAM_STOPWATCH_LAP_EN, the lap and lap_bcd ports and the capture register SHALL be absent and all other behaviour identical.

Verification (DVSR=4, DIGITS=4)
REQ-035 Bench: reset, go=1, up=1 for 40 cycles -> bcd=0x0010, first d0 increment exactly 4 cycles after go rises.
REQ-036 Bench: load 0x9599, go=1, up=1 -> after 4 cycles bcd=0x0000, wrap_tick high one cycle, running stays 1.
REQ-037 Bench: load 0x0002, go=1, up=0 -> after 8 cycles bcd=0x0000, done_tick one pulse, expired=1; further go=1 leaves bcd=0x0000.
REQ-038 Bench: load 0xFA7C -> bcd=0x9579; load and tick in the same cycle -> loaded value wins.
REQ-039 Bench: reset asserted mid-run between clock edges -> outputs zero immediately, before the next edge.
REQ-040 Bench (LAP_EN): lap at bcd=0x0005 while running -> lap_bcd=0x0005 with counting uninterrupted; clr -> lap_bcd=0.

Source files
------------

// File: rtl/param_stopwatch.sv
// BCD stopwatch / countdown timer with a DVSR-cycle tenths prescaler and IDLE/RUN/DONE control.
// Optional lap capture register enabled by defining PARAM_STOPWATCH_LAP_EN.
module param_stopwatch #(
    parameter int DVSR   = 10000000,
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                go,
    input  logic                clr,
    input  logic                up,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
`ifdef PARAM_STOPWATCH_LAP_EN
    input  logic                lap,
    output logic [4*DIGITS-1:0] lap_bcd,
`endif
    output logic [4*DIGITS-1:0] bcd,
    output logic                running,
    output logic                expired,
    output logic                done_tick,
    output logic                wrap_tick
);

    // state | meaning
    // IDLE  | stopped, prescaler holds, waiting for go
    // RUN   | prescaler counting, digits update on each tick
    // DONE  | countdown reached zero, held until clr/load/reset
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int W  = 4 * DIGITS;
    localparam int PW = (DVSR > 1) ? $clog2(DVSR) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DVSR - 1);

    state_t          state, next_state;
    logic [PW-1:0]   presc, next_presc;
    logic [W-1:0]    digits, next_digits;
    logic            next_done, next_wrap;

    logic [W-1:0]    inc_val, dec_val, sat_val;
    logic            all_max, all_zero;

    function automatic logic [3:0] digit_mod(input int k);
        return (k == 2 || k == 4) ? 4'd6 : 4'd10;
    endfunction

    // Ripple carry/borrow: a digit moves only while every lower digit is at its limit.
    always_comb begin
        inc_val  = digits;
        dec_val  = digits;
        sat_val  = '0;
        all_max  = 1'b1;
        all_zero = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (all_max)
                inc_val[4*k +: 4] = (digits[4*k +: 4] == digit_mod(k) - 4'd1)
                                    ? 4'd0 : digits[4*k +: 4] + 4'd1;
            if (all_zero)
                dec_val[4*k +: 4] = (digits[4*k +: 4] == 4'd0)
                                    ? digit_mod(k) - 4'd1 : digits[4*k +: 4] - 4'd1;
            all_max  = all_max  & (digits[4*k +: 4] == digit_mod(k) - 4'd1);
            all_zero = all_zero & (digits[4*k +: 4] == 4'd0);
            sat_val[4*k +: 4] = (load_val[4*k +: 4] >= digit_mod(k))
                                ? digit_mod(k) - 4'd1 : load_val[4*k +: 4];
        end
    end

    // The prescaler advances in the cycle go is accepted, so the first tick
    // lands exactly DVSR cycles after go is first sampled high.
    always_comb begin
        next_state  = state;
        next_presc  = presc;
        next_digits = digits;
        next_done   = 1'b0;
        next_wrap   = 1'b0;
        if (clr) begin
            next_state  = IDLE;
            next_presc  = '0;
            next_digits = '0;
        end else if (load) begin
            next_state  = IDLE;
            next_presc  = '0;
            next_digits = sat_val;
        end else begin
            case (state)
                IDLE, RUN: begin
                    if (!go) begin
                        next_state = IDLE;
                    end else begin
                        next_state = RUN;
                        if (presc == PRESC_LAST) begin
                            next_presc = '0;
                            if (up) begin
                                next_digits = inc_val;
                                next_wrap   = all_max;
                            end else if (all_zero) begin
                                next_state = DONE;
                                next_done  = 1'b1;
                            end else begin
                                next_digits = dec_val;
                                if (dec_val == '0) begin
                                    next_state = DONE;
                                    next_done  = 1'b1;
                                end
                            end
                        end else begin
                            next_presc = presc + 1'b1;
                        end
                    end
                end
                DONE: next_state = DONE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            presc     <= '0;
            digits    <= '0;
            done_tick <= 1'b0;
            wrap_tick <= 1'b0;
            running   <= 1'b0;
            expired   <= 1'b0;
        end else begin
            state     <= next_state;
            presc     <= next_presc;
            digits    <= next_digits;
            done_tick <= next_done;
            wrap_tick <= next_wrap;
            running   <= (next_state == RUN);
            expired   <= (next_state == DONE);
        end
    end

    assign bcd = digits;

`ifdef PARAM_STOPWATCH_LAP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            lap_bcd <= '0;
        else if (clr)
            lap_bcd <= '0;
        else if (lap)
            lap_bcd <= digits;
    end
`endif

endmodule

// File: tb/tb_param_stopwatch.sv
// Directed, table-driven bench for param_stopwatch at DVSR=4, DIGITS=4.
// Lap checks are compiled in when PARAM_STOPWATCH_LAP_EN is defined.
module tb_param_stopwatch;

    logic        clk = 1'b0;
    logic        reset;
    logic        go, clr, up, load;
    logic [15:0] load_val;
    logic [15:0] bcd;
    logic        running, expired, done_tick, wrap_tick;
`ifdef PARAM_STOPWATCH_LAP_EN
    logic        lap;
    logic [15:0] lap_bcd;
`endif

    int checks = 0;
    int errors = 0;

    param_stopwatch #(.DVSR(4), .DIGITS(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .go       (go),
        .clr      (clr),
        .up       (up),
        .load     (load),
        .load_val (load_val),
`ifdef PARAM_STOPWATCH_LAP_EN
        .lap      (lap),
        .lap_bcd  (lap_bcd),
`endif
        .bcd      (bcd),
        .running  (running),
        .expired  (expired),
        .done_tick(done_tick),
        .wrap_tick(wrap_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          ld;
        logic [15:0] lv;
        bit          go;
        bit          up;
        bit          clr;
        int          n;
        logic [15:0] bcd;
        bit          run;
        bit          exp;
        bit          dtk;
        bit          wtk;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit ld, logic [15:0] lv, bit g, bit u, bit c, int n,
                                logic [15:0] b, bit r, bit e, bit d, bit w);
        vec_t v;
        v.ld = ld; v.lv = lv; v.go = g; v.up = u; v.clr = c; v.n = n;
        v.bcd = b; v.run = r; v.exp = e; v.dtk = d; v.wtk = w;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [15:0] b, input bit r,
                                 input bit e, input bit d, input bit w);
        check({tag, " bcd"},       32'(bcd),       32'(b));
        check({tag, " running"},   32'(running),   32'(r));
        check({tag, " expired"},   32'(expired),   32'(e));
        check({tag, " done_tick"}, 32'(done_tick), 32'(d));
        check({tag, " wrap_tick"}, 32'(wrap_tick), 32'(w));
    endtask

    initial begin
        reset = 1'b1; go = 1'b0; clr = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
`ifdef PARAM_STOPWATCH_LAP_EN
        lap = 1'b0;
`endif

        // count up from zero, 10 ticks in 40 cycles
        vecs.push_back(mk(0, 16'h0000, 0, 1, 1, 1,  16'h0000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 1, 0, 3,  16'h0000, 1, 0, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 1, 0, 1,  16'h0001, 1, 0, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 1, 0, 36, 16'h0010, 1, 0, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 0, 1, 0, 2,  16'h0010, 0, 0, 0, 0));
        // full-scale rollover
        vecs.push_back(mk(1, 16'h9599, 0, 1, 0, 1,  16'h9599, 0, 0, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 1, 0, 3,  16'h9599, 1, 0, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 1, 0, 1,  16'h0000, 1, 0, 0, 1));
        vecs.push_back(mk(0, 16'h0000, 1, 1, 0, 1,  16'h0000, 1, 0, 0, 0));
        // countdown to expiry, then DONE holds
        vecs.push_back(mk(1, 16'h0002, 0, 0, 0, 1,  16'h0002, 0, 0, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 3,  16'h0002, 1, 0, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 1,  16'h0001, 1, 0, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 3,  16'h0001, 1, 0, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 1,  16'h0000, 0, 1, 1, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 1,  16'h0000, 0, 1, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 1, 0, 8,  16'h0000, 0, 1, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 0, 1, 1, 1,  16'h0000, 0, 0, 0, 0));
        // load saturation
        vecs.push_back(mk(1, 16'hFA7C, 0, 1, 0, 1,  16'h9579, 0, 0, 0, 0));
        // load coinciding with a tick
        vecs.push_back(mk(1, 16'h0000, 0, 1, 0, 1,  16'h0000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 1, 0, 3,  16'h0000, 1, 0, 0, 0));
        vecs.push_back(mk(1, 16'h1234, 1, 1, 0, 1,  16'h1234, 0, 0, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 1, 0, 1,  16'h1234, 1, 0, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 1, 0, 3,  16'h1235, 1, 0, 0, 0));
        // direction change mid-run
        vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 4,  16'h1234, 1, 0, 0, 0));
        // borrow and carry through every digit
        vecs.push_back(mk(1, 16'h1000, 0, 0, 0, 1,  16'h1000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 4,  16'h0599, 1, 0, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 1, 0, 4,  16'h1000, 1, 0, 0, 0));
        // countdown tick while already zero
        vecs.push_back(mk(1, 16'h0000, 0, 0, 0, 1,  16'h0000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 3,  16'h0000, 1, 0, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 0, 1,  16'h0000, 0, 1, 1, 0));
        // clr beats load
        vecs.push_back(mk(1, 16'h5555, 0, 1, 1, 1,  16'h0000, 0, 0, 0, 0));

        repeat (2) @(negedge clk);
        check_outputs("reset", 16'h0000, 0, 0, 0, 0);
`ifdef PARAM_STOPWATCH_LAP_EN
        check("reset lap_bcd", 32'(lap_bcd), 32'h0);
`endif
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            load = vecs[i].ld; load_val = vecs[i].lv; go = vecs[i].go;
            up = vecs[i].up;   clr = vecs[i].clr;
            repeat (vecs[i].n) @(posedge clk);
            @(negedge clk);
            check_outputs($sformatf("row%0d", i), vecs[i].bcd, vecs[i].run,
                          vecs[i].exp, vecs[i].dtk, vecs[i].wtk);
        end
        load = 1'b0; clr = 1'b0;

        // asynchronous reset between edges discards partial prescaler count
        go = 1'b1; up = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("pre-reset bcd", 32'(bcd), 32'h0001);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("async reset bcd", 32'(bcd), 32'h0000);
        check("async reset running", 32'(running), 32'h0);
        go = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        go = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("post-reset no early tick", 32'(bcd), 32'h0000);
        @(posedge clk);
        @(negedge clk);
        check("post-reset first tick", 32'(bcd), 32'h0001);

`ifdef PARAM_STOPWATCH_LAP_EN
        go = 1'b0; clr = 1'b1;
        @(negedge clk);
        clr = 1'b0; go = 1'b1; up = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("lap pre bcd", 32'(bcd), 32'h0005);
        lap = 1'b1;
        @(negedge clk);
        lap = 1'b0;
        check("lap capture", 32'(lap_bcd), 32'h0005);
        check("lap running", 32'(running), 32'h1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("lap counting continues", 32'(bcd), 32'h0006);
        load = 1'b1; load_val = 16'h0100;
        @(negedge clk);
        load = 1'b0;
        check("lap after load", 32'(lap_bcd), 32'h0005);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("lap after clr", 32'(lap_bcd), 32'h0000);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
